// File: rtl/blink_meter_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | blink_meter_pkg : shared constants and state encoding for the       |
// |                   LED blinker / blink meter pair                    |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package blink_meter_pkg;

  localparam int CNT_W_DEFAULT     = 27;
  localparam int TIMEOUT_DEFAULT   = 100000000;
  localparam int BLINK_HALF_PERIOD = 25000000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/blink_meter_sync_edge.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | blink_meter_sync_edge : two-flop synchronizer plus delay flop,      |
// |                         giving a clean level and edge strobes       |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module blink_meter_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign level = r_s3;
  assign rise  = r_s2 & ~r_s3;
  assign fall  = ~r_s2 & r_s3;

endmodule
`default_nettype wire

// File: rtl/blink_meter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | blink_meter : measures high time, low time and period of an async   |
// |               line in clk cycles, with a sticky stuck-line flag     |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module blink_meter
  import blink_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr_stuck,
  output logic             level,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             valid,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] C_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_timeout;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_cnt_nxt;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_have_high;
  logic             w_have_high_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [CNT_W-1:0] w_high_nxt;
  logic [CNT_W-1:0] w_low_nxt;
  logic [CNT_W:0]   w_period_nxt;
  logic             w_valid_nxt;
  logic             w_stuck_nxt;

  blink_meter_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .level (level),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  assign w_edge = w_rise | w_fall;

  // Counter saturates, so the threshold compare fires once per edge-free stretch.
  assign w_timeout = (r_cnt == C_TIMEOUT_M1) && !w_edge;
  assign w_len     = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_ONE;
  assign w_cnt_nxt = w_edge ? '0 : w_len;

  always_comb begin
    w_state_nxt     = r_state;
    w_have_high_nxt = r_have_high;
    w_hold_nxt      = r_hold;
    w_high_nxt      = high_len;
    w_low_nxt       = low_len;
    w_period_nxt    = period;
    w_valid_nxt     = 1'b0;
    w_stuck_nxt     = stuck;

    if (clr_stuck) begin
      w_stuck_nxt = 1'b0;
    end

    if (w_timeout) begin
      w_stuck_nxt     = 1'b1;
      w_have_high_nxt = 1'b0;
      w_state_nxt     = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_nxt = MEAS_HIGH;
          end else if (w_fall) begin
            w_state_nxt = WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (w_rise) begin
            w_state_nxt = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (w_fall) begin
            w_hold_nxt      = w_len;
            w_have_high_nxt = 1'b1;
            w_state_nxt     = MEAS_LOW;
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            if (r_have_high) begin
              w_high_nxt   = r_hold;
              w_low_nxt    = w_len;
              w_period_nxt = {1'b0, r_hold} + {1'b0, w_len};
              w_valid_nxt  = 1'b1;
            end
            w_state_nxt = MEAS_HIGH;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_have_high <= 1'b0;
      r_cnt       <= '0;
      r_hold      <= '0;
      high_len    <= '0;
      low_len     <= '0;
      period      <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_have_high <= w_have_high_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      high_len    <= w_high_nxt;
      low_len     <= w_low_nxt;
      period      <= w_period_nxt;
      valid       <= w_valid_nxt;
      stuck       <= w_stuck_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blink_meter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_blink_meter : directed stimulus with a queue-based scoreboard    |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_blink_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 40;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             sig_in    = 1'b0;
  logic             clr_stuck = 1'b0;
  logic             level;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W:0]   period;
  logic             valid;
  logic             stuck;

  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] l;
    logic [CNT_W:0]   p;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  blink_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .clr_stuck (clr_stuck),
    .level     (level),
    .high_len  (high_len),
    .low_len   (low_len),
    .period    (period),
    .valid     (valid),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int h, input int l);
    exp_t e;
    e.h = CNT_W'(h);
    e.l = CNT_W'(l);
    e.p = (CNT_W+1)'(h + l);
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic v, input int n);
    sig_in = v;
    cycles(n);
  endtask

  task automatic pulse(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},    {31'd0, level},  32'd0);
    check({tag, "_high_len"}, 32'(high_len),   32'd0);
    check({tag, "_low_len"},  32'(low_len),    32'd0);
    check({tag, "_period"},   32'(period),     32'd0);
    check({tag, "_valid"},    {31'd0, valid},  32'd0);
    check({tag, "_stuck"},    {31'd0, stuck},  32'd0);
  endtask

  // Monitor: every valid cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid=1 (high_len=%0d low_len=%0d) expected no strobe (t=%0t)",
                 high_len, low_len, $time);
      end else begin
        mon_e = sb.pop_front();
        check("high_len", 32'(high_len), 32'(mon_e.h));
        check("low_len",  32'(low_len),  32'(mon_e.l));
        check("period",   32'(period),   32'(mon_e.p));
      end
    end
  end

  initial begin
    cycles(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cycles(2);

    // 5/7 square wave: first strobe only after the second rise
    pulse(5, 7);
    push(5, 7); pulse(5, 7);
    push(5, 7); pulse(5, 7);
    push(5, 7); pulse(5, 7);

    // duty change to 3/9; old values hold until the next strobe
    push(5, 7); pulse(3, 9);
    check("hold_before_strobe", 32'(high_len), 32'd5);
    push(3, 9); pulse(3, 9);
    push(3, 9); pulse(3, 9);

    // line held high: stuck appears exactly TIMEOUT cycles after the edge
    push(3, 9);
    sig_in = 1'b1;
    cycles(42);
    check("stuck_before_timeout", {31'd0, stuck}, 32'd0);
    cycles(1);
    check("stuck_at_timeout", {31'd0, stuck}, 32'd1);
    cycles(17);
    clr_stuck = 1'b1;
    cycles(1);
    clr_stuck = 1'b0;
    check("stuck_cleared", {31'd0, stuck}, 32'd0);
    cycles(30);
    check("stuck_not_reraised", {31'd0, stuck}, 32'd0);

    // resume after timeout: partial phase discarded
    hold(1'b0, 7);
    pulse(5, 7);
    push(5, 7); pulse(5, 7);
    push(5, 7); pulse(5, 7);

    // reset in the middle of a high phase
    sig_in = 1'b1;
    cycles(1);
    rst_n = 1'b0;
    cycles(2);
    check_all_zero("midreset");
    sig_in = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(2);

    // two rises needed again, then a high phase exactly at the threshold
    pulse(5, 7);
    push(5, 7); pulse(40, 7);
    check("stuck_coincident_edge", {31'd0, stuck}, 32'd0);
    push(40, 7);
    hold(1'b1, 3);
    check("level_high", {31'd0, level}, 32'd1);
    hold(1'b0, 3);
    cycles(5);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
